// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and helpers for the sram_ctrl Wishbone-to-SRAM bridge.
//   state_t : controller state (IDLE, ACTIVE, GAP, DONE)
//   clog2   : ceiling log2, used for the beat-index and wait-counter widths
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        GAP,
        DONE
    } state_t;

    function automatic int clog2(input int unsigned v);
        int          r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: pipelined Wishbone slave driving an asynchronous SRAM narrower than
// the bus. Each bus word is split into NB = DW/RW beats, beat 0 carrying the most
// significant RAM word. Write beats with no byte selected are skipped.
//   i_clk, i_reset                : clock, synchronous active-high reset
//   i_wb_cyc/stb/we/addr/data/sel : Wishbone request
//   o_wb_stall/ack/data           : Wishbone response
//   o_ram_ce_n/oe_n/we_n          : SRAM strobes, active low
//   o_ram_addr                    : {word address, beat index}
//   o_ram_data, o_ram_sel         : write data, active-low byte lanes
//   o_ram_drive                   : pad output enable (write beats only)
//   i_ram_data                    : read data from the pad
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW      = 15,
    parameter int DW      = 32,
    parameter int RW      = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_wb_cyc,
    input  logic                       i_wb_stb,
    input  logic                       i_wb_we,
    input  logic [AW-1:0]              i_wb_addr,
    input  logic [DW-1:0]              i_wb_data,
    input  logic [DW/8-1:0]            i_wb_sel,
    output logic                       o_wb_stall,
    output logic                       o_wb_ack,
    output logic [DW-1:0]              o_wb_data,
    output logic                       o_ram_ce_n,
    output logic                       o_ram_oe_n,
    output logic                       o_ram_we_n,
    output logic [AW+clog2(DW/RW)-1:0] o_ram_addr,
    output logic [RW-1:0]              o_ram_data,
    output logic                       o_ram_drive,
    output logic [RW/8-1:0]            o_ram_sel,
    input  logic [RW-1:0]              i_ram_data
);

    localparam int NB   = DW / RW;
    localparam int LGNB = clog2(NB);
    localparam int BW   = (LGNB > 0) ? LGNB : 1;
    localparam int SB   = RW / 8;
    localparam int CW   = clog2(((RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT) + 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

    state_t            r_state, w_next;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_data;
    logic [DW/8-1:0]   r_sel;
    logic              r_we;
    logic [BW-1:0]     r_beat;
    logic [CW-1:0]     r_wait;
    logic              r_abort;
    logic [DW-1:0]     r_rdata;

    logic              w_accept;
    logic              w_active;
    logic [NB-1:0]     w_in_en, w_cur_en;
    logic              w_in_found, w_nx_found;
    logic [BW-1:0]     w_in_beat, w_nx_beat;
    logic [RW-1:0]     w_beat_data;
    logic [SB-1:0]     w_beat_sel;

    assign w_accept = (r_state == IDLE || r_state == DONE) && i_wb_cyc && i_wb_stb;
    assign w_active = (r_state == ACTIVE);

    // Priority scans: first live beat of the incoming request, and the next live
    // beat after the current one. Reads use every beat.
    always_comb begin
        w_in_en    = '0;
        w_cur_en   = '0;
        w_in_found = 1'b0;
        w_in_beat  = '0;
        w_nx_found = 1'b0;
        w_nx_beat  = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_in_en[i]  = !i_wb_we || (|i_wb_sel[DW/8-1-i*SB -: SB]);
            w_cur_en[i] = !r_we || (|r_sel[DW/8-1-i*SB -: SB]);
        end
        for (int unsigned i = 0; i < NB; i++) begin
            if (w_in_en[i] && !w_in_found) begin
                w_in_found = 1'b1;
                w_in_beat  = BW'(i);
            end
            if (w_cur_en[i] && !w_nx_found && (BW'(i) > r_beat)) begin
                w_nx_found = 1'b1;
                w_nx_beat  = BW'(i);
            end
        end
    end

    always_comb begin
        w_beat_data = '0;
        w_beat_sel  = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (BW'(i) == r_beat) begin
                w_beat_data = r_data[DW-1-i*RW -: RW];
                w_beat_sel  = r_sel[DW/8-1-i*SB -: SB];
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        o_wb_stall  = 1'b1;
        o_wb_ack    = 1'b0;
        o_ram_ce_n  = 1'b1;
        o_ram_oe_n  = 1'b1;
        o_ram_we_n  = 1'b1;
        o_ram_drive = 1'b0;
        o_ram_sel   = '1;
        unique case (r_state)
            IDLE: begin
                o_wb_stall = 1'b0;
                if (w_accept) w_next = w_in_found ? ACTIVE : DONE;
            end
            ACTIVE: begin
                o_ram_ce_n  = 1'b0;
                o_ram_oe_n  = r_we;
                o_ram_we_n  = !r_we;
                o_ram_drive = r_we;
                o_ram_sel   = r_we ? ~w_beat_sel : '0;
                // The beat always runs to completion; a dropped cyc only stops the next one.
                if (r_wait == '0)
                    w_next = (w_nx_found && i_wb_cyc && !r_abort) ? GAP : DONE;
            end
            GAP: begin
                w_next = i_wb_cyc ? ACTIVE : DONE;
            end
            DONE: begin
                o_wb_stall = 1'b0;
                o_wb_ack   = i_wb_cyc && !r_abort;
                w_next     = w_accept ? (w_in_found ? ACTIVE : DONE) : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_beat  <= '0;
            r_wait  <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= i_wb_addr;
                r_data  <= i_wb_data;
                r_sel   <= i_wb_sel;
                r_we    <= i_wb_we;
                r_beat  <= w_in_beat;
                r_wait  <= i_wb_we ? WR_LOAD : RD_LOAD;
                r_abort <= 1'b0;
            end else if (r_state == ACTIVE) begin
                if (!i_wb_cyc) r_abort <= 1'b1;
                if (r_wait != '0) begin
                    r_wait <= r_wait - 1'b1;
                end else begin
                    r_wait <= r_we ? WR_LOAD : RD_LOAD;
                    if (w_next == GAP) r_beat <= w_nx_beat;
                end
            end else if (r_state == GAP && !i_wb_cyc) begin
                r_abort <= 1'b1;
            end
        end
    end

    // Read data is not reset; it is only meaningful in the ack cycle.
    always_ff @(posedge i_clk) begin
        if (w_active && r_wait == '0 && !r_we) begin
            for (int unsigned i = 0; i < NB; i++)
                if (BW'(i) == r_beat) r_rdata[DW-1-i*RW -: RW] <= i_ram_data;
        end
    end

    assign o_wb_data  = r_rdata;
    assign o_ram_data = w_beat_data;

    generate
        if (LGNB > 0) begin : g_beat_addr
            assign o_ram_addr = {r_addr, r_beat};
        end else begin : g_word_addr
            assign o_ram_addr = r_addr;
        end
    endgenerate

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl. A word-level reference memory
// predicts read data, ack latency and strobe count at request time; a monitor
// compares when ack appears. A second instance (DW=64, RD_WAIT=3) covers reset
// in the middle of an access.
`timescale 1ns/1ps
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycnt    = 0;
    always @(posedge clk) cycnt <= cycnt + 1;

    // Main instance, default parameters
    logic        rst, cyc, stb, we;
    logic [14:0] addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  sel;
    logic        stall, ack, ce_n, oe_n, we_n, drive;
    logic [15:0] raddr, rwdata, rrdata;
    logic [1:0]  rsel;

    sram_ctrl #(.AW(15), .DW(32), .RW(16), .RD_WAIT(2), .WR_WAIT(2)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdata),
        .o_ram_ce_n(ce_n), .o_ram_oe_n(oe_n), .o_ram_we_n(we_n), .o_ram_addr(raddr),
        .o_ram_data(rwdata), .o_ram_drive(drive), .o_ram_sel(rsel), .i_ram_data(rrdata)
    );

    // Second instance: 64-bit bus, four beats, three-cycle reads
    logic        c2_rst, c2_cyc, c2_stb, c2_we;
    logic [14:0] c2_addr;
    logic [63:0] c2_wdata, c2_rdata;
    logic [7:0]  c2_sel;
    logic        c2_stall, c2_ack, c2_ce_n, c2_oe_n, c2_we_n, c2_drive;
    logic [16:0] c2_raddr;
    logic [15:0] c2_rwdata, c2_rrdata;
    logic [1:0]  c2_rsel;

    sram_ctrl #(.AW(15), .DW(64), .RW(16), .RD_WAIT(3), .WR_WAIT(2)) u_dut64 (
        .i_clk(clk), .i_reset(c2_rst), .i_wb_cyc(c2_cyc), .i_wb_stb(c2_stb), .i_wb_we(c2_we),
        .i_wb_addr(c2_addr), .i_wb_data(c2_wdata), .i_wb_sel(c2_sel),
        .o_wb_stall(c2_stall), .o_wb_ack(c2_ack), .o_wb_data(c2_rdata),
        .o_ram_ce_n(c2_ce_n), .o_ram_oe_n(c2_oe_n), .o_ram_we_n(c2_we_n), .o_ram_addr(c2_raddr),
        .o_ram_data(c2_rwdata), .o_ram_drive(c2_drive), .o_ram_sel(c2_rsel), .i_ram_data(c2_rrdata)
    );

    // RAM models
    logic [15:0] mem     [0:65535];
    logic [31:0] ref_mem [0:32767];
    assign rrdata    = (!ce_n && !oe_n) ? mem[raddr] : 16'h0F0F;
    assign c2_rrdata = (!c2_ce_n && !c2_oe_n) ? (16'(c2_raddr) ^ 16'hC3C3) : 16'h0000;

    typedef struct {
        logic        we;
        logic [31:0] data;
        int          acc;
        int          lat;
        int          nstb;
        int          stb0;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  sel;
        logic        we_n;
    } tr_t;
    tr_t trace[$];

    int   strobes = 0;
    logic ce_prev = 1'b1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: RAM write side, strobe trace, invariants, scoreboard pop on ack
    always @(negedge clk) begin
        exp_t e;
        if (!ce_n) begin
            trace.push_back('{cycnt, raddr, rwdata, rsel, we_n});
            if (ce_prev) strobes++;
            if (!we_n) begin
                if (!rsel[1]) mem[raddr][15:8] = rwdata[15:8];
                if (!rsel[0]) mem[raddr][7:0]  = rwdata[7:0];
            end
            chk("oe_we_exclusive", 64'(oe_n ^ we_n), 64'(1));
            chk("drive_on_write", 64'(drive), 64'(!we_n));
        end else begin
            chk("ce_high_quiet", 64'({oe_n, we_n, drive, rsel}), 64'(5'b11011));
        end
        ce_prev = ce_n;
        if (ack) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: ack=1 with nothing pending, required ack=0 (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("ack_latency", 64'(cycnt - e.acc), 64'(e.lat));
                chk("strobe_count", 64'(strobes - e.stb0), 64'(e.nstb));
                if (!e.we) chk("read_data", 64'(rdata), 64'(e.data));
            end
        end
    end

    task automatic req(input logic w, input logic [14:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit exp_ack, output int acc);
        int n;
        int k;
        n = 0;
        k = 0;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        while (stall && n < 64) begin
            @(negedge clk);
            n++;
        end
        acc = cycnt;
        if (n >= 64) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: stall still 1 after %0d cycles, required 0", n);
            stb = 1'b0;
            return;
        end
        // Beats that move data: every beat for reads, byte-pairs with any select for writes
        for (int b = 0; b < 2; b++) if (!w || s[3-2*b -: 2] != 2'b00) k++;
        if (exp_ack) begin
            sb.push_back('{w, ref_mem[a], acc, (k == 0) ? 1 : 3 * k, k, strobes});
            if (w) for (int i = 0; i < 4; i++) if (s[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a1, a2, n;
        logic [63:0] exp64;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        c2_rst = 1'b1; c2_cyc = 1'b0; c2_stb = 1'b0; c2_we = 1'b0; c2_addr = '0;
        c2_wdata = '0; c2_sel = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 32768; i++) ref_mem[i] = 32'h0;
        mem[16'h2468] = 16'hAAAA;
        mem[16'h2469] = 16'h5555;
        ref_mem[15'h1234] = 32'hAAAA5555;
        repeat (3) @(negedge clk);

        chk("reset_wb", 64'({stall, ack}), 64'(0));
        chk("reset_strobes", 64'({ce_n, oe_n, we_n, drive, rsel}), 64'(6'b111011));
        chk("reset_addr_data", 64'({raddr, rwdata}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Read, two beats: strobes in cycles 1-2 and 4-5, ack at 6
        trace.delete();
        req(1'b0, 15'h1234, 32'h0, 4'hF, 1'b1, a1);
        drain();
        chk("rd_beat_cycles", 64'(trace.size()), 64'(4));
        for (int i = 0; i < 4 && i < trace.size(); i++) begin
            chk("rd_cycle", 64'(trace[i].cyc - a1), 64'((i < 2) ? i + 1 : i + 2));
            chk("rd_addr", 64'(trace[i].addr), 64'((i < 2) ? 16'h2468 : 16'h2469));
            chk("rd_sel", 64'(trace[i].sel), 64'(0));
        end

        // Write with upper half masked: only beat 1 strobes
        trace.delete();
        req(1'b1, 15'h0300, 32'hDEADBEEF, 4'b0011, 1'b1, a1);
        drain();
        chk("wr_skip_cycles", 64'(trace.size()), 64'(2));
        if (trace.size() > 0) begin
            chk("wr_skip_first", 64'(trace[0].cyc - a1), 64'(1));
            chk("wr_skip_beat", 64'({trace[0].addr, trace[0].data, trace[0].sel, trace[0].we_n}),
                64'({16'h0601, 16'hBEEF, 2'b00, 1'b0}));
        end
        chk("wr_skip_mem", 64'({mem[16'h0600], mem[16'h0601]}), 64'(32'h0000BEEF));

        // Fully masked write: no strobe, ack at cycle 1
        trace.delete();
        req(1'b1, 15'h0301, 32'h12345678, 4'b0000, 1'b1, a1);
        drain();
        chk("wr_nosel_strobes", 64'(trace.size()), 64'(0));

        // Back-to-back reads with stb held
        trace.delete();
        req(1'b0, 15'h1234, 32'h0, 4'hF, 1'b1, a1);
        req(1'b0, 15'h0300, 32'h0, 4'hF, 1'b1, a2);
        drain();
        chk("b2b_accept_spacing", 64'(a2 - a1), 64'(6));
        chk("b2b_beat_cycles", 64'(trace.size()), 64'(8));
        if (trace.size() >= 8) chk("b2b_ce_gap", 64'(trace[4].cyc - trace[3].cyc), 64'(2));

        // cyc dropped in cycle 2 of a write: beat 0 finishes, no beat 1, no ack
        trace.delete();
        req(1'b1, 15'h0100, 32'h12345678, 4'hF, 1'b0, a1);
        @(negedge clk);
        cyc = 1'b0;
        @(negedge clk);
        chk("abort_wr_release", 64'({stall, ack}), 64'(0));
        repeat (4) @(negedge clk);
        chk("abort_wr_cycles", 64'(trace.size()), 64'(2));
        chk("abort_wr_mem", 64'({mem[16'h0200], mem[16'h0201]}), 64'(32'h12340000));

        // cyc dropped in GAP of a read: straight to DONE, no second beat
        trace.delete();
        req(1'b0, 15'h1234, 32'h0, 4'hF, 1'b0, a1);
        @(negedge clk);
        @(negedge clk);
        cyc = 1'b0;
        @(negedge clk);
        chk("abort_gap_release", 64'({stall, ack}), 64'(0));
        repeat (3) @(negedge clk);
        chk("abort_gap_cycles", 64'(trace.size()), 64'(2));

        // Random traffic over a small address window
        for (int t = 0; t < 80; t++) begin
            req(1'($urandom_range(0, 1)), 15'($urandom_range(0, 7)), $urandom, 4'($urandom),
                1'b1, a1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        // Reset in the GAP of a 4-beat read on the 64-bit instance
        c2_rst = 1'b0;
        @(negedge clk);
        c2_cyc = 1'b1; c2_stb = 1'b1; c2_we = 1'b0; c2_addr = 15'h0ABC; c2_sel = '1;
        @(negedge clk);
        c2_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst64_beat0_active", 64'(c2_ce_n), 64'(0));
        @(negedge clk);
        chk("rst64_gap", 64'(c2_ce_n), 64'(1));
        c2_rst = 1'b1;
        @(negedge clk);
        c2_rst = 1'b0;
        chk("rst64_wb", 64'({c2_stall, c2_ack}), 64'(0));
        chk("rst64_strobes", 64'({c2_ce_n, c2_oe_n, c2_we_n, c2_drive, c2_rsel}), 64'(6'b111011));
        chk("rst64_addr_data", 64'({c2_raddr, c2_rwdata}), 64'(0));
        repeat (4) begin
            @(negedge clk);
            chk("rst64_no_ack", 64'(c2_ack), 64'(0));
        end
        c2_stb = 1'b1; c2_addr = 15'h0155;
        a1 = cycnt;
        @(negedge clk);
        c2_stb = 1'b0;
        n = 1;
        while (!c2_ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst64_ack", 64'(c2_ack), 64'(1));
        chk("rst64_latency", 64'(cycnt - a1), 64'(16));
        for (int b = 0; b < 4; b++) exp64[63-16*b -: 16] = 16'(15'h0155 * 4 + b) ^ 16'hC3C3;
        chk("rst64_read_data", c2_rdata, exp64);
        @(negedge clk);
        c2_cyc = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
